// File: rtl/shift_pipe_vr_pkg.sv
// rtl/shift_pipe_vr_pkg.sv - shared helpers for the elastic shift pipeline
package shift_pipe_vr_pkg;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_pipe_vr_stage.sv
// rtl/shift_pipe_vr_stage.sv - one valid/data stage of the elastic shift pipeline
module pipe_stage_vr #(
    parameter int DATA_W      = 32,
    parameter int LANES       = 1,
    parameter int RST_DATA_EN = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic [LANES-1:0][DATA_W-1:0]  data_i,
    output logic                          valid_o,
    output logic [LANES-1:0][DATA_W-1:0]  data_o
);

    logic                         valid_q, valid_d;
    logic [LANES-1:0][DATA_W-1:0] data_q, data_d;

    // Bubbles clear the valid bit but leave the last real beat in the data register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            if (RST_DATA_EN != 0) begin
                data_q <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/shift_pipe_vr.sv
// rtl/shift_pipe_vr.sv - stallable valid/ready fixed-latency shift pipeline with taps
module shift_pipe_vr
    import shift_pipe_vr_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int LANES           = 1,
    parameter int PIPE_DEPTH      = 4,
    parameter int RST_DATA_EN     = 0,
    parameter int BUBBLE_COLLAPSE = 1,
    localparam int CNT_W          = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    input  logic [LANES-1:0][DATA_W-1:0]                  data_i,
    output logic                                          valid_o,
    input  logic                                          ready_i,
    output logic [LANES-1:0][DATA_W-1:0]                  data_o,
    output logic [PIPE_DEPTH-1:0]                         tap_valid_o,
    output logic [PIPE_DEPTH-1:0][LANES-1:0][DATA_W-1:0]  tap_data_o,
    output logic [CNT_W-1:0]                              occupancy_o
);

    typedef logic [LANES-1:0][DATA_W-1:0] lane_t;

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] adv;
    logic [PIPE_DEPTH-1:0] up_valid;
    logic [PIPE_DEPTH-1:0] valid_nxt;
    lane_t                 up_data    [PIPE_DEPTH];
    lane_t                 stage_data [PIPE_DEPTH];
    logic [CNT_W-1:0]      occupancy_q, occupancy_d;

    // Advance chain walks back from the output; a scalar carry avoids a self-reading vector.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = ready_i || !valid_q[PIPE_DEPTH-1];
        adv[PIPE_DEPTH-1] = carry;
        for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
            if (BUBBLE_COLLAPSE != 0) begin
                carry = carry || !valid_q[k];
            end
            adv[k] = carry;
        end
    end

    genvar g;
    generate
        for (g = 0; g < PIPE_DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign up_valid[g] = valid_i;
                assign up_data[g]  = data_i;
            end else begin : g_body
                assign up_valid[g] = valid_q[g-1];
                assign up_data[g]  = stage_data[g-1];
            end

            pipe_stage_vr #(
                .DATA_W      (DATA_W),
                .LANES       (LANES),
                .RST_DATA_EN (RST_DATA_EN)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load_i  (adv[g]),
                .flush_i (flush_i),
                .valid_i (up_valid[g]),
                .data_i  (up_data[g]),
                .valid_o (valid_q[g]),
                .data_o  (stage_data[g])
            );

            assign tap_data_o[g] = stage_data[g];
        end
    endgenerate

    always_comb begin
        valid_nxt = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            valid_nxt[k] = flush_i ? 1'b0 : (adv[k] ? up_valid[k] : valid_q[k]);
        end
        occupancy_d = CNT_W'(popcount(64'(valid_nxt)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign ready_o     = adv[0] && !flush_i;
    assign valid_o     = valid_q[PIPE_DEPTH-1] && !flush_i;
    assign data_o      = stage_data[PIPE_DEPTH-1];
    assign tap_valid_o = valid_q;
    assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_shift_pipe_vr.sv
// tb/tb_shift_pipe_vr.sv - randomized self-checking bench for shift_pipe_vr
module tb_shift_pipe_vr;

    localparam int D  = 4;
    localparam int W  = 16;
    localparam int L  = 2;
    localparam int BW = W * L;

    logic clk = 1'b0;
    logic rst, flush_i, valid_i, ready_i;
    logic [L-1:0][W-1:0] data_i;

    logic a_ready, a_valid, b_ready, b_valid;
    logic [L-1:0][W-1:0] a_data, b_data;
    logic [D-1:0] a_tapv, b_tapv;
    logic [D-1:0][L-1:0][W-1:0] a_tapd, b_tapd;
    logic [2:0] a_occ, b_occ;

    always #5 clk = ~clk;

    shift_pipe_vr #(.DATA_W(W), .LANES(L), .PIPE_DEPTH(D), .RST_DATA_EN(1), .BUBBLE_COLLAPSE(1)) u_a (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(a_ready),
        .data_i(data_i), .valid_o(a_valid), .ready_i(ready_i), .data_o(a_data),
        .tap_valid_o(a_tapv), .tap_data_o(a_tapd), .occupancy_o(a_occ));

    shift_pipe_vr #(.DATA_W(W), .LANES(L), .PIPE_DEPTH(D), .RST_DATA_EN(0), .BUBBLE_COLLAPSE(0)) u_b (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(b_ready),
        .data_i(data_i), .valid_o(b_valid), .ready_i(ready_i), .data_o(b_data),
        .tap_valid_o(b_tapv), .tap_data_o(b_tapd), .occupancy_o(b_occ));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference: each in-flight beat is a (data, position) record, oldest first.
    typedef struct {
        logic [BW-1:0] data;
        int            pos;
    } beat_t;

    beat_t         qa[$], qb[$];
    logic [BW-1:0] last_a [D], last_b [D];
    bit            known_a[D], known_b[D];

    function automatic bit m_ready(input beat_t q[$], input bit collapse, input bit rdy);
        if (collapse) return rdy || (q.size() < D);
        return rdy || !(q.size() > 0 && q[0].pos == D - 1);
    endfunction

    task automatic check_one(input string n, input int i, input logic rdy_o, input logic vld_o,
                             input logic [BW-1:0] dat_o, input logic [D-1:0] tv,
                             input logic [D*BW-1:0] td, input logic [2:0] occ);
        beat_t         q[$];
        logic [BW-1:0] last[D];
        bit            known[D];
        logic [D-1:0]  exp_tv;
        if (i == 0) begin q = qa; last = last_a; known = known_a; end
        else        begin q = qb; last = last_b; known = known_b; end
        exp_tv = '0;
        foreach (q[j]) exp_tv[q[j].pos] = 1'b1;
        chk({n, "_ready"}, rdy_o, !flush_i && m_ready(q, i == 0, ready_i));
        chk({n, "_valid"}, vld_o, exp_tv[D-1] && !flush_i);
        chk({n, "_tapv"}, tv, exp_tv);
        chk({n, "_occ"}, occ, q.size());
        if (known[D-1]) chk({n, "_data"}, dat_o, last[D-1]);
        for (int p = 0; p < D; p++) begin
            if (known[p]) chk($sformatf("%s_tapd%0d", n, p), td[p*BW +: BW], last[p]);
        end
    endtask

    task automatic model_step(input int i, input bit vin, input logic [BW-1:0] din, input bit rdy,
                              input bit fl, input bit rs);
        beat_t         q[$], nq[$];
        logic [BW-1:0] last[D];
        bit            known[D];
        bit            collapse, ok;
        int            ahead, np;
        collapse = (i == 0);
        if (i == 0) begin q = qa; last = last_a; known = known_a; end
        else        begin q = qb; last = last_b; known = known_b; end
        if (rs || fl) begin
            q.delete();
            if (rs && i == 0) begin
                for (int p = 0; p < D; p++) begin last[p] = '0; known[p] = 1'b1; end
            end
        end else begin
            ok    = m_ready(q, collapse, rdy);
            ahead = D;
            foreach (q[j]) begin
                if (q[j].pos == D - 1) begin
                    np = (collapse ? rdy : ok) ? -1 : D - 1;
                end else if (collapse) begin
                    np = (q[j].pos + 1 != ahead) ? q[j].pos + 1 : q[j].pos;
                end else begin
                    np = ok ? q[j].pos + 1 : q[j].pos;
                end
                if (np >= 0) begin
                    nq.push_back('{q[j].data, np});
                    last[np]  = q[j].data;
                    known[np] = 1'b1;
                    ahead     = np;
                end else begin
                    ahead = D;
                end
            end
            if (vin && ok) begin
                nq.push_back('{din, 0});
                last[0]  = din;
                known[0] = 1'b1;
            end
            q = nq;
        end
        if (i == 0) begin qa = q; last_a = last; known_a = known; end
        else        begin qb = q; last_b = last; known_b = known; end
    endtask

    task automatic cyc(input bit v, input logic [BW-1:0] d, input bit r, input bit f, input bit rs);
        @(negedge clk);
        valid_i = v; data_i = d; ready_i = r; flush_i = f; rst = rs;
        #1;
        if (!rs) begin
            check_one("a", 0, a_ready, a_valid, a_data, a_tapv, a_tapd, a_occ);
            check_one("b", 1, b_ready, b_valid, b_data, b_tapv, b_tapd, b_occ);
        end
        model_step(0, v, d, r, f, rs);
        model_step(1, v, d, r, f, rs);
    endtask

    initial begin
        for (int p = 0; p < D; p++) begin known_a[p] = 1'b0; known_b[p] = 1'b0; end
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Back-to-back stream, downstream always ready.
        for (int i = 0; i < 8; i++) cyc(1, 32'h10 + i, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);

        // Stall: six offered, only the depth can be absorbed.
        for (int i = 0; i < 6; i++) cyc(1, 32'h20 + i, 0, 0, 0);
        @(posedge clk); #1;
        chk("stall_full_occ", a_occ, D);
        chk("stall_full_ready", a_ready, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);

        // Beat/bubble/beat under stall: collapse squeezes, lock-step keeps the gap.
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h31, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h33, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("squeeze_collapse_taps", a_tapv, 4'b1100);
        chk("squeeze_lockstep_taps", b_tapv, 4'b1010);
        cyc(1, 32'h34, 0, 0, 0);

        // Flush with both sides willing: nothing moves, then empty.
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h40 + i, 0, 0, 0);
        cyc(1, 32'h4f, 1, 1, 0);
        @(posedge clk); #1;
        chk("flush_occ", a_occ, 0);
        chk("flush_valid", a_valid, 0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1, 32'h50 + i, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        @(posedge clk); #1;
        chk("rst_taps_cleared", a_tapd, '0);
        chk("rst_tapv", b_tapv, 0);
        cyc(0, 0, 1, 0, 0);

        // Random soak.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                ($urandom % 60) == 0, ($urandom % 150) == 0);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
